// File: rtl/fft_delay_buf_if.sv
// Stream bundle for fft_delay_buf: input beat handshake plus the butterfly operand pair output.
interface fft_delay_buf_if #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16
);
  logic                             din_valid;
  logic                             din_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_q;
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] dly_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] dly_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] cur_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] cur_q;
  logic                             bfly_en;
  logic                             frame_done;

  modport master (
    output din_valid, din_i, din_q, out_ready,
    input  din_ready, out_valid, dly_i, dly_q, cur_i, cur_q, bfly_en, frame_done
  );

  modport slave (
    input  din_valid, din_i, din_q, out_ready,
    output din_ready, out_valid, dly_i, dly_q, cur_i, cur_q, bfly_en, frame_done
  );
endinterface

// File: rtl/fft_delay_buf.sv
// FFT delay-line buffer: pairs each beat with the one accepted D beats earlier.
// Optional macro FFT_DELAY_BUF_LEVEL_EN exposes the fill level on 'level'.
//
// state | meaning
// FILL  | first D beats of a frame are written to the ring buffer, no output
// PAIR  | next D beats are emitted together with their delayed partner
module fft_delay_buf #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16,
  parameter int MAX_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [$clog2(MAX_DEPTH):0]      cfg_depth,
  input  logic                            flush,
  fft_delay_buf_if.slave                  s,
  output logic [$clog2(MAX_DEPTH):0]      level
);
  localparam int AW = $clog2(MAX_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = LANES * DATA_WIDTH;
  localparam int BW = 2 * HW;
  localparam logic [CW-1:0] DMAX = CW'(MAX_DEPTH);

  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   d_reg, d_cur, d_cfg;
  logic [CW:0]     two_d_m1;
  logic            first;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [BW-1:0]   mem [MAX_DEPTH];
  logic [BW-1:0]   cur_r, dly_r;
  logic            out_valid_r, frame_done_r;
  logic            acc, fill_acc, pair_acc, fill_last, pair_last;

  // Out-of-range requests collapse to the full depth.
  assign d_cfg = (cfg_depth == '0 || cfg_depth > DMAX) ? DMAX : cfg_depth;
  // On the first clock after reset the fresh cfg_depth is already in force.
  assign d_cur    = first ? d_cfg : d_reg;
  assign two_d_m1 = {d_cur, 1'b0} - (CW+1)'(1);

  assign fill_last = (cnt == d_cur - CW'(1));
  assign pair_last = ({1'b0, cnt} == two_d_m1);
  assign acc       = s.din_valid && s.din_ready && !flush;
  assign fill_acc  = acc && (state == FILL);
  assign pair_acc  = acc && (state == PAIR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)                       state_nxt = FILL;
    else if (fill_acc && fill_last)  state_nxt = PAIR;
    else if (pair_acc && pair_last)  state_nxt = FILL;
  end

  always_comb begin
    s.din_ready = 1'b1;
    if (state == PAIR) s.din_ready = !out_valid_r || s.out_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      first        <= 1'b1;
      d_reg        <= DMAX;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      cur_r        <= '0;
      dly_r        <= '0;
    end else begin
      first        <= 1'b0;
      frame_done_r <= 1'b0;
      if (first) d_reg <= d_cfg;
      if (flush) begin
        cnt         <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        d_reg       <= d_cfg;
        out_valid_r <= 1'b0;
      end else begin
        if (fill_acc) begin
          cnt    <= cnt + CW'(1);
          wr_ptr <= fill_last ? '0 : wr_ptr + AW'(1);
        end
        if (pair_acc) begin
          cur_r        <= {s.din_i, s.din_q};
          dly_r        <= mem[rd_ptr];
          out_valid_r  <= 1'b1;
          frame_done_r <= pair_last;
          if (pair_last) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            d_reg  <= d_cfg;
          end else begin
            cnt    <= cnt + CW'(1);
            rd_ptr <= rd_ptr + AW'(1);
          end
        end else if (s.out_ready) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  // Ring storage is never read before being written within a frame, so no reset.
  always_ff @(posedge clk) begin
    if (fill_acc) mem[wr_ptr] <= {s.din_i, s.din_q};
  end

  assign s.out_valid  = out_valid_r;
  assign s.bfly_en    = out_valid_r;
  assign s.frame_done = frame_done_r;
  assign s.cur_i      = cur_r[BW-1:HW];
  assign s.cur_q      = cur_r[HW-1:0];
  assign s.dly_i      = dly_r[BW-1:HW];
  assign s.dly_q      = dly_r[HW-1:0];

`ifdef FFT_DELAY_BUF_LEVEL_EN
  assign level = (state == FILL) ? cnt : d_reg;
`else
  assign level = '0;
`endif
endmodule

// File: tb/tb_fft_delay_buf.sv
// Self-checking bench for fft_delay_buf: directed table, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_fft_delay_buf;
  localparam int DW = 9;
  localparam int L  = 16;
  localparam int MD = 16;
  localparam int CW = $clog2(MD) + 1;
  localparam int BW = 2 * L * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] cfg_depth = CW'(4);
  logic [CW-1:0] level;

  fft_delay_buf_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

  fft_delay_buf #(.DATA_WIDTH(DW), .LANES(L), .MAX_DEPTH(MD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_depth (cfg_depth),
    .flush     (flush),
    .s         (bus),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int v);
    logic [L-1:0][DW-1:0] ii, qq;
    for (int l = 0; l < L; l++) begin
      ii[l] = DW'(v * 3 + l);
      qq[l] = DW'(-v - l);
    end
    return {ii, qq};
  endfunction

  function automatic int sat(input int c);
    return (c == 0 || c > MD) ? MD : c;
  endfunction

  // Reference model: a frame is 2*D beats; beat k>=D pairs with beat k-D.
  int            pos, m_d, d_now;
  bit            m_first, rdy_now, exp_valid, exp_fd;
  logic [BW-1:0] exp_cur, exp_dly, beat_now;
  logic [BW-1:0] fbuf [MD];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos = 0; m_d = MD; m_first = 1; exp_valid = 0; exp_fd = 0;
      exp_cur = '0; exp_dly = '0;
    end else begin
      d_now = m_first ? sat(int'(cfg_depth)) : m_d;
      if (m_first) begin m_d = d_now; m_first = 0; end
      rdy_now  = (pos < d_now) || !exp_valid || bus.out_ready;
      beat_now = {bus.din_i, bus.din_q};
      if (flush) begin
        pos = 0; exp_valid = 0; exp_fd = 0; m_d = sat(int'(cfg_depth));
      end else begin
        exp_fd = 0;
        if (bus.din_valid && rdy_now && pos < d_now) begin
          fbuf[pos] = beat_now;
          pos++;
          if (bus.out_ready) exp_valid = 0;
        end else if (bus.din_valid && rdy_now) begin
          exp_dly   = fbuf[pos - d_now];
          exp_cur   = beat_now;
          exp_valid = 1;
          exp_fd    = (pos == 2 * d_now - 1);
          pos++;
          if (pos == 2 * d_now) begin pos = 0; m_d = sat(int'(cfg_depth)); end
        end else if (bus.out_ready) begin
          exp_valid = 0;
        end
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", BW'(bus.out_valid), BW'(exp_valid));
      chk("bfly_en", BW'(bus.bfly_en), BW'(exp_valid));
      chk("frame_done", BW'(bus.frame_done), BW'(exp_fd));
      chk("din_ready", BW'(bus.din_ready), BW'((pos < m_d) || !exp_valid || bus.out_ready));
`ifdef FFT_DELAY_BUF_LEVEL_EN
      chk("level", BW'(level), BW'((pos < m_d) ? pos : m_d));
`else
      chk("level", BW'(level), BW'(0));
`endif
      if (exp_valid) begin
        chk("cur", {bus.cur_i, bus.cur_q}, exp_cur);
        chk("dly", {bus.dly_i, bus.dly_q}, exp_dly);
      end
    end
  end

  task automatic drive(input bit v, input int val, input bit ordy, input bit fl);
    bus.din_valid = v;
    {bus.din_i, bus.din_q} = mk(val);
    bus.out_ready = ordy;
    flush = fl;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    bit fl; bit v; int val; bit ordy; int cfg;
    bit e_ov; int e_dly; int e_cur; bit e_fd;
  } vec_t;

  vec_t tbl[$];
  int   npair, nfd;

  initial begin
    drive(0, 0, 1, 0);
    @(negedge clk); #1;
    chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
    chk("rst_frame_done", BW'(bus.frame_done), BW'(0));
    chk("rst_cur", {bus.cur_i, bus.cur_q}, BW'(0));
    chk("rst_dly", {bus.dly_i, bus.dly_q}, BW'(0));
    chk("rst_level", BW'(level), BW'(0));
    rstn = 1'b1;
    chk_en = 1;

    // Directed table: D=4 frame of 1..8, then D=1 frame pair-per-beat.
    tbl.push_back('{1, 1, 99, 1, 4, 0, 0, 0, 0});
    for (int k = 1; k <= 4; k++) tbl.push_back('{0, 1, k, 1, 4, 0, 0, 0, 0});
    for (int k = 5; k <= 8; k++) tbl.push_back('{0, 1, k, 1, 4, 1, k - 4, k, k == 8});
    tbl.push_back('{0, 0, 0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 2, 1, 1, 1, 1, 2, 1});
    tbl.push_back('{0, 1, 3, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 1, 1, 1, 3, 4, 1});
    foreach (tbl[i]) begin
      cfg_depth = CW'(tbl[i].cfg);
      drive(tbl[i].v, tbl[i].val, tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_ov", i), BW'(bus.out_valid), BW'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_fd", i), BW'(bus.frame_done), BW'(tbl[i].e_fd));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_dly", i), {bus.dly_i, bus.dly_q}, mk(tbl[i].e_dly));
        chk($sformatf("tbl%0d_cur", i), {bus.cur_i, bus.cur_q}, mk(tbl[i].e_cur));
      end
      #1;
    end

    // Back-pressure: first pair held, input stalled, then next frame fills under a held pair.
    cfg_depth = CW'(4);
    drive(0, 0, 1, 1); step();
    for (int k = 1; k <= 4; k++) begin drive(1, k, 1, 0); step(); end
    drive(1, 5, 0, 0); step();
    for (int c = 0; c < 4; c++) begin
      drive(1, 6, 0, 0);
      chk("stall_ready", BW'(bus.din_ready), BW'(0));
      chk("stall_cur", {bus.cur_i, bus.cur_q}, mk(5));
      chk("stall_dly", {bus.dly_i, bus.dly_q}, mk(1));
      step();
    end
    for (int k = 6; k <= 8; k++) begin drive(1, k, 1, 0); step(); end
    drive(1, 9, 0, 0);
    chk("b2b_ready", BW'(bus.din_ready), BW'(1));
    step();
    chk("b2b_hold_cur", {bus.cur_i, bus.cur_q}, mk(8));
    chk("b2b_hold_ov", BW'(bus.out_valid), BW'(1));
    drive(0, 0, 1, 0); step();

    // Flush after three FILL beats, then a clean frame 10..17.
    drive(0, 0, 1, 1); step();
    for (int k = 1; k <= 3; k++) begin drive(1, k, 1, 0); step(); end
    drive(1, 50, 1, 1); step();
    for (int k = 10; k <= 17; k++) begin
      drive(1, k, 1, 0); step();
      if (k >= 14) begin
        chk("flush_cur", {bus.cur_i, bus.cur_q}, mk(k));
        chk("flush_dly", {bus.dly_i, bus.dly_q}, mk(k - 4));
      end
    end

    // cfg_depth=0 selects full depth; a mid-frame change waits for the frame end.
    cfg_depth = '0;
    drive(0, 0, 1, 1); step();
    npair = 0; nfd = 0;
    for (int k = 0; k < 32; k++) begin
      if (k == 10) cfg_depth = CW'(2);
      drive(1, 100 + k, 1, 0); step();
      if (bus.out_valid) npair++;
      if (bus.frame_done) nfd++;
    end
    chk("d16_pairs", BW'(npair), BW'(16));
    chk("d16_done", BW'(nfd), BW'(1));
    npair = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 200 + k, 1, 0); step();
      if (bus.out_valid) npair++;
    end
    chk("d2_pairs", BW'(npair), BW'(2));

    // Asynchronous reset in the middle of PAIR.
    cfg_depth = CW'(4);
    drive(0, 0, 1, 1); step();
    for (int k = 1; k <= 6; k++) begin drive(1, k, 1, 0); step(); end
    rstn = 1'b0;
    #1;
    chk("arst_ov", BW'(bus.out_valid), BW'(0));
    chk("arst_fd", BW'(bus.frame_done), BW'(0));
    chk("arst_cur", {bus.cur_i, bus.cur_q}, BW'(0));
    chk("arst_dly", {bus.dly_i, bus.dly_q}, BW'(0));
    chk("arst_level", BW'(level), BW'(0));
    rstn = 1'b1;
    for (int k = 21; k <= 28; k++) begin drive(1, k, 1, 0); step(); end

    // Randomized traffic with occasional reconfiguration and flush.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) cfg_depth = CW'($urandom_range(0, MD + 3));
      bus.din_valid = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < L; l++) begin
        bus.din_i[l] = DW'($urandom);
        bus.din_q[l] = DW'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 149) == 0);
      step();
    end

    drive(0, 0, 1, 0);
    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
